// File: rtl/if_id_skid_pkg.sv
// Shared widths, bubble instruction and exception codes for the IF/ID skid register.
package if_id_pkg;
  localparam int          PC_W_DEF     = 32;
  localparam int          INST_W_DEF   = 32;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
  localparam int          EXC_W        = 5;
  localparam logic [EXC_W-1:0] EXC_NONE = 5'h00;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'h04;
endpackage

// File: rtl/if_id_skid_pipe_slot.sv
// One pipeline slot: valid bit plus payload with synchronous reset, clear, load and hold.
module pipe_slot #(
  parameter int           W       = 8,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
      data_d  = CLR_VAL;
    end else if (load_i) begin
      valid_d = valid_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= CLR_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/if_id_skid.sv
// IF/ID pipeline register with valid/ready handshake, one-entry skid slot and flush.
// Define IF_ID_EXCEPT_EN to carry a fetch exception code alongside pc/inst.
module if_id_skid
  import if_id_pkg::*;
#(
  parameter int                PC_W     = PC_W_DEF,
  parameter int                INST_W   = INST_W_DEF,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [PC_W-1:0]   if_pc,
  input  logic [INST_W-1:0] if_inst,
`ifdef IF_ID_EXCEPT_EN
  input  logic [EXC_W-1:0]  if_excode,
  output logic [EXC_W-1:0]  id_excode,
`endif
  output logic              id_valid,
  input  logic              id_ready,
  output logic [PC_W-1:0]   id_pc,
  output logic [INST_W-1:0] id_inst,
  input  logic              id_flush
);
`ifdef IF_ID_EXCEPT_EN
  localparam int PW = EXC_W + PC_W + INST_W;
`else
  localparam int PW = PC_W + INST_W;
`endif
  // Bubble payload: zero pc/excode with the NOP in the low bits.
  localparam logic [PW-1:0] BUBBLE = PW'(NOP_INST);

  logic          main_v, skid_v;
  logic [PW-1:0] main_data, skid_data, in_data;
  logic          main_free, acc_in;
  logic          main_vin, skid_load, skid_vin;
  logic [PW-1:0] main_din, skid_din;

`ifdef IF_ID_EXCEPT_EN
  // A faulting fetch must never reach decode as a real instruction.
  assign in_data = {if_excode, if_pc, (if_excode != EXC_NONE) ? NOP_INST : if_inst};
  assign {id_excode, id_pc, id_inst} = main_data;
`else
  assign in_data = {if_pc, if_inst};
  assign {id_pc, id_inst} = main_data;
`endif

  assign if_ready  = !skid_v;
  assign acc_in    = if_valid & !skid_v;
  assign main_free = !main_v | id_ready;

  assign main_vin  = skid_v | acc_in;
  assign main_din  = skid_v ? skid_data : (acc_in ? in_data : BUBBLE);

  // Skid fills on a stalled accept and empties whenever main takes its entry.
  assign skid_load = (!main_free & acc_in) | (main_free & skid_v);
  assign skid_vin  = !main_free;
  assign skid_din  = main_free ? BUBBLE : in_data;

  pipe_slot #(.W(PW), .CLR_VAL(BUBBLE)) u_main (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (id_flush),
    .load_i  (main_free),
    .valid_i (main_vin),
    .data_i  (main_din),
    .valid_o (main_v),
    .data_o  (main_data)
  );

  pipe_slot #(.W(PW), .CLR_VAL(BUBBLE)) u_skid (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (id_flush),
    .load_i  (skid_load),
    .valid_i (skid_vin),
    .data_i  (skid_din),
    .valid_o (skid_v),
    .data_o  (skid_data)
  );

  assign id_valid = main_v;
endmodule

// File: tb/tb_if_id_skid.sv
// Scoreboard bench for if_id_skid: directed handshake/flush/reset cases plus random traffic.
module tb_if_id_skid;
  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  exc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, if_valid, id_ready, id_flush;
  logic        if_ready, id_valid;
  logic [31:0] if_pc, if_inst, id_pc, id_inst;
  logic [4:0]  if_excode;
`ifdef IF_ID_EXCEPT_EN
  logic [4:0]  id_excode;
`endif

  ent_t sb[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  if_id_skid dut (
    .clk      (clk),
    .rst      (rst),
    .if_valid (if_valid),
    .if_ready (if_ready),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
`ifdef IF_ID_EXCEPT_EN
    .if_excode(if_excode),
    .id_excode(id_excode),
`endif
    .id_valid (id_valid),
    .id_ready (id_ready),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .id_flush (id_flush)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the edge; the queue mirrors what the
  // block holds, so an offer is accepted exactly when fewer than two are held.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic rdy, input logic fl, input logic rs, input logic [4:0] exc);
    ent_t e;
    @(posedge clk);
    #1;
    rst       = rs;
    id_flush  = fl;
    if_valid  = v;
    if_pc     = pc;
    if_inst   = inst;
    if_excode = exc;
    id_ready  = (rs || fl) ? 1'b0 : rdy;
    if (rs || fl) sb.delete();
    else if (v && sb.size() < 2) begin
      e.pc   = pc;
      e.inst = (exc != 5'd0) ? NOP : inst;
      e.exc  = exc;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b0, 5'd0);
  endtask

  always @(negedge clk) begin
    ent_t e;
    if (mon_en) begin
      if (!id_valid) begin
        check("bubble_pc", id_pc, 32'h0);
        check("bubble_inst", id_inst, NOP);
      end
      if (id_valid && id_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out_pc", id_pc, 32'hDEAD_BEEF);
        end else begin
          e = sb.pop_front();
          check("out_pc", id_pc, e.pc);
          check("out_inst", id_inst, e.inst);
`ifdef IF_ID_EXCEPT_EN
          check("out_exc", {27'd0, id_excode}, {27'd0, e.exc});
`endif
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_valid = 1'b0; id_ready = 1'b0; id_flush = 1'b0;
    if_pc = '0; if_inst = '0; if_excode = '0;

    // Reset held two cycles with fetch offering.
    drive(1'b1, 32'h40, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 5'd0);
    drive(1'b1, 32'h44, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 5'd0);
    idle(1'b0);
    @(negedge clk);
    check("rst_id_valid", {31'd0, id_valid}, 32'd0);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_id_inst", id_inst, NOP);
    check("rst_if_ready", {31'd0, if_ready}, 32'd1);
    mon_en = 1'b1;

    // Streaming at one per cycle.
    drive(1'b1, 32'h0, 32'h3C01_0001, 1'b1, 1'b0, 1'b0, 5'd0);
    drive(1'b1, 32'h4, 32'h3C01_0002, 1'b1, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    check("str0_valid", {31'd0, id_valid}, 32'd1);
    check("str0_pc", id_pc, 32'h0);
    drive(1'b1, 32'h8, 32'h3C01_0003, 1'b1, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    check("str1_valid", {31'd0, id_valid}, 32'd1);
    check("str1_pc", id_pc, 32'h4);
    idle(1'b1);
    @(negedge clk);
    check("str2_valid", {31'd0, id_valid}, 32'd1);
    check("str2_inst", id_inst, 32'h3C01_0003);
    idle(1'b1);

    // Stall fills main then skid.
    drive(1'b1, 32'h0, 32'hA000_0000, 1'b0, 1'b0, 1'b0, 5'd0);
    drive(1'b1, 32'h4, 32'hA000_0004, 1'b0, 1'b0, 1'b0, 5'd0);
    idle(1'b0);
    @(negedge clk);
    check("stall_valid", {31'd0, id_valid}, 32'd1);
    check("stall_pc", id_pc, 32'h0);
    check("stall_if_ready", {31'd0, if_ready}, 32'd0);
    idle(1'b1);
    idle(1'b1);
    @(negedge clk);
    check("skid_drain_pc", id_pc, 32'h4);
    idle(1'b1);

    // Flush with a same-cycle offer.
    drive(1'b1, 32'h8, 32'hB000_0008, 1'b0, 1'b0, 1'b0, 5'd0);
    drive(1'b1, 32'hC, 32'hB000_000C, 1'b0, 1'b0, 1'b0, 5'd0);
    drive(1'b1, 32'h10, 32'hB000_0010, 1'b0, 1'b1, 1'b0, 5'd0);
    idle(1'b0);
    @(negedge clk);
    check("flush_valid", {31'd0, id_valid}, 32'd0);
    check("flush_pc", id_pc, 32'h0);
    check("flush_if_ready", {31'd0, if_ready}, 32'd1);
    idle(1'b1);
    @(negedge clk);
    check("flush_no_0x10", {31'd0, id_valid}, 32'd0);

`ifdef IF_ID_EXCEPT_EN
    drive(1'b1, 32'h2, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 5'h04);
    idle(1'b0);
    @(negedge clk);
    check("exc_code", {27'd0, id_excode}, 32'd4);
    check("exc_inst", id_inst, NOP);
    check("exc_pc", id_pc, 32'h2);
    idle(1'b1);
    idle(1'b1);
`endif

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, {$urandom_range(0, 4095), 2'b00}, $urandom,
            ($urandom % 3) != 0, ($urandom % 40) == 0, 1'b0, 5'd0);
    end

    // Reset while the skid is full.
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0);
    drive(1'b1, 32'h100, 32'hC000_0100, 1'b0, 1'b0, 1'b0, 5'd0);
    drive(1'b1, 32'h104, 32'hC000_0104, 1'b0, 1'b0, 1'b0, 5'd0);
    idle(1'b0);
    @(negedge clk);
    check("pre_rst_if_ready", {31'd0, if_ready}, 32'd0);
    drive(1'b1, 32'h108, 32'hC000_0108, 1'b1, 1'b0, 1'b1, 5'd0);
    idle(1'b0);
    @(negedge clk);
    check("mrst_valid", {31'd0, id_valid}, 32'd0);
    check("mrst_pc", id_pc, 32'h0);
    check("mrst_inst", id_inst, NOP);
    check("mrst_if_ready", {31'd0, if_ready}, 32'd1);

    // Final drain: anything still expected must come out within a few cycles.
    drive(1'b1, 32'h200, 32'hD000_0200, 1'b1, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 8 && sb.size() != 0; i++) begin
      idle(1'b1);
      @(negedge clk);
      #1;
    end
    check("drain_left", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
